// File: rtl/ysyx_22040000_rf_write_arbiter.sv
// ysyx_22040000_rf_write_arbiter
// Shares the single register-file write port between two writeback sources.
// Channel 0 carries EXU results and channel 1 carries LSU load data. The two
// channels are granted round-robin through a valid/ready handshake, and the
// winning write reaches the register file through one registered stage. The
// block also keeps a per-register busy scoreboard. The issue stage reserves a
// destination register at dispatch and queries source registers for hazards.
//
// Ports
//   clk, rst                  clock; asynchronous active-high reset
//   rsv_valid, rsv_addr       reserve a destination register (mark it busy)
//   rsv_conflict              comb: the reserved register is already busy
//   reqN_valid/addr/data      write request on channel N (0 = EXU, 1 = LSU)
//   reqN_ready                comb grant; a write is accepted on valid & ready
//   rf_wen/waddr/wdata        registered register-file write port
//   chk_addrN, chk_busyN      source-register hazard query
module ysyx_22040000_rf_write_arbiter #(
  parameter int unsigned AWIDTH = 5,
  parameter int unsigned DWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              rsv_valid,
  input  logic [AWIDTH-1:0] rsv_addr,
  output logic              rsv_conflict,

  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [AWIDTH-1:0] req0_addr,
  input  logic [DWIDTH-1:0] req0_data,

  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [AWIDTH-1:0] req1_addr,
  input  logic [DWIDTH-1:0] req1_data,

  output logic              rf_wen,
  output logic [AWIDTH-1:0] rf_waddr,
  output logic [DWIDTH-1:0] rf_wdata,

  input  logic [AWIDTH-1:0] chk_addr1,
  input  logic [AWIDTH-1:0] chk_addr2,
  output logic              chk_busy1,
  output logic              chk_busy2
);

  localparam int unsigned NREG = 1 << AWIDTH;

  // Last granted channel. It resets to 1 so that channel 0 wins the first contest.
  logic              last_q;
  logic [NREG-1:0]   busy_q;
  logic [NREG-1:0]   busy_d;

  logic              gnt0;
  logic              gnt1;
  logic              accept;
  logic [AWIDTH-1:0] acc_addr;
  logic [DWIDTH-1:0] acc_data;

  // Round-robin grant. It depends only on the two valids and last_q,
  // so no path runs from the write port back to ready.
  always_comb begin
    gnt0 = req0_valid & (~req1_valid | last_q);
    gnt1 = req1_valid & (~req0_valid | ~last_q);
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign accept     = gnt0 | gnt1;

  // Selects the payload of the granted channel.
  always_comb begin
    acc_addr = req0_addr;
    acc_data = req0_data;
    if (gnt1) begin
      acc_addr = req1_addr;
      acc_data = req1_data;
    end
  end

  // Arbitration pointer. It follows every grant, contested or not.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= 1'b1;
    end else if (accept) begin
      last_q <= gnt1;
    end
  end

  // Output stage. Writes to x0 are consumed here without raising rf_wen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_wen   <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else if (accept) begin
      rf_wen   <= (acc_addr != '0);
      rf_waddr <= acc_addr;
      rf_wdata <= acc_data;
    end else begin
      rf_wen   <= 1'b0;
    end
  end

  // Scoreboard next state. The clear is applied first and the reserve second,
  // so a same-cycle reserve of the register being written wins: the new
  // producer owns the register. Entry 0 is never busy.
  always_comb begin
    busy_d = busy_q;
    for (int unsigned i = 1; i < NREG; i++) begin
      if (accept && (acc_addr == AWIDTH'(i))) begin
        busy_d[i] = 1'b0;
      end
      if (rsv_valid && (rsv_addr == AWIDTH'(i))) begin
        busy_d[i] = 1'b1;
      end
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // Hazard query on registered state only. The output-stage term keeps a
  // register busy until the register file has actually captured the write.
  always_comb begin
    chk_busy1    = busy_q[chk_addr1]
                 | (rf_wen & (rf_waddr == chk_addr1) & (chk_addr1 != '0));
    chk_busy2    = busy_q[chk_addr2]
                 | (rf_wen & (rf_waddr == chk_addr2) & (chk_addr2 != '0));
    rsv_conflict = rsv_valid
                 & (busy_q[rsv_addr]
                    | (rf_wen & (rf_waddr == rsv_addr) & (rsv_addr != '0)));
  end

endmodule

// File: doc/ysyx_22040000_rf_write_arbiter.md
# ysyx_22040000_rf_write_arbiter

Arbitrates the single register-file write port between two writeback requesters: channel 0 is the EXU result and channel 1 is the LSU load data. Grants are round-robin through a valid/ready handshake, and the winning write is driven to the register file through a registered output stage. The block also holds a per-register busy scoreboard. The issue stage reserves a destination at dispatch and queries source registers for hazard stalls.

## Interface
- AWIDTH, 5, register address width; the scoreboard has 2**AWIDTH entries.
- DWIDTH, 32, write data width.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- rsv_valid  in  1  reserve destination rsv_addr this cycle.
- rsv_addr  in  AWIDTH  destination register to mark busy.
- rsv_conflict  out  1  combinational: rsv_valid & chk(rsv_addr) busy; a diagnostic only.
- req0_valid / req1_valid  in  1  write request present on channel 0 / 1.
- req0_ready / req1_ready  out  1  combinational grant; the write is accepted when valid & ready.
- req0_addr / req1_addr  in  AWIDTH  destination register.
- req0_data / req1_data  in  DWIDTH  write data.
- rf_wen  out  1  register-file write enable (registered).
- rf_waddr  out  AWIDTH  register-file write address (registered).
- rf_wdata  out  DWIDTH  register-file write data (registered).
- chk_addr1 / chk_addr2  in  AWIDTH  source registers to check.
- chk_busy1 / chk_busy2  out  1  combinational: the register has an outstanding write.

## Operation
- **Arbitration state:** a 1-bit `last` holds the last granted channel. Reset value is 1, so channel 0 wins the first contest.
- **Grant rules:**
  - Only one valid: that channel is granted.
  - Both valid: the channel != `last` is granted.
  - Neither valid: no grant.
- **`last` update:** loads the granted channel index on every grant, contested or not.
- **Ready timing:** ready never depends on the register-file state; the port is never backpressured. Exactly one ready is high whenever at least one valid is high.
- **Output stage on accept:**
  - rf_waddr and rf_wdata load the granted address and data.
  - rf_wen loads (granted addr != 0).
- **Output stage with no accept:** rf_wen loads 0, and rf_waddr / rf_wdata hold their values.
- **Writes to x0:** accepted and consumed, but never produce rf_wen and never touch the scoreboard.
- **Scoreboard:** busy_q[2**AWIDTH-1:0]. busy_q[0] is hard-wired to 0.
  - **Set:** at the edge where rsv_valid is high and rsv_addr != 0.
  - **Clear:** at the edge where a write to that address is accepted.
  - **Simultaneous set and clear of the same address:** set wins; the new producer owns the register.
  - **Reserving an already-busy register:** the bit stays 1 (no count). rsv_conflict flags it. Issue logic must not do this.
- **Busy query:** chk_busyN = busy_q[chk_addrN] | (rf_wen & rf_waddr == chk_addrN & chk_addrN != 0).
  - The second term covers the cycle where the write sits in the output stage and the register file has not yet captured it.
  - The query does not see same-cycle rsv_valid or same-cycle accepts; it reflects registered state only.
- **Reset:** asynchronous and immediate.
  - All outputs go to 0: rf_wen=0, rf_waddr=0, rf_wdata=0.
  - busy_q is all 0 and `last`=1.
  - An in-flight output-stage write is dropped.
  - Ready outputs stay combinational, but accepts during rst are discarded.

## Timing
- **Accept at edge N** (valid & ready high in the cycle before edge N):
  - rf_wen, rf_waddr and rf_wdata are valid in cycle N.
  - The register file captures the write at edge N+1.
  - Data is readable from cycle N+1 onward.
- **Scoreboard bit:**
  - Cleared at edge N.
  - chk_busy stays 1 through cycle N via the output-stage term, and drops in cycle N+1.
- **Reserve at edge M:** chk_busy reads 1 from cycle M.
- **Throughput:** one write per cycle. Under continuous contention the channels alternate 0,1,0,1…; neither starves for more than 1 cycle.
- **Combinational paths:** ready depends only on both valids and `last`. There is no path from rf_* to ready.

## Test plan
- **Reset:** assert rst mid-write, with rf_wen=1 and busy_q[5]=1.
  - rf_wen, rf_waddr and rf_wdata read 0 immediately, before the next clk edge.
  - All chk_busy read 0.
  - With both valid held after release, the first grant goes to channel 0.
- **Contention:** hold req0 (addr 3, 0x11) and req1 (addr 4, 0x22) valid for 4 cycles.
  - Grants alternate 0,1,0,1.
  - rf_waddr sequence is 3,4,3,4, with rf_wen=1 each cycle starting one cycle after the first accept.
- **Scoreboard lifecycle:**
  - Reserve x7, then query: chk_busy1=1.
  - Accept req1 to x7: chk_busy1 stays 1 in the rf_wen cycle and reads 0 one cycle later.
  - A register-file read of x7 two cycles after the accept returns the written data.
- **x0 write:** req0 to addr 0 with data 0xDEADBEEF.
  - req0_ready=1 and rf_wen stays 0.
  - chk_busy for addr 0 always reads 0, including after rsv_valid with rsv_addr=0.
- **Simultaneous set and clear:** in one cycle, rsv x9 and accept a write to x9 (x9 previously busy).
  - busy_q[9] remains 1 afterwards.
  - rsv_conflict=1 in that cycle.
- **Single requester:** only req1 valid for 3 cycles, then both valid.
  - req1 is granted for the 3 cycles.
  - The first contested grant goes to channel 0, because `last`=1.
